// File: rtl/ppu_pkg.sv
// Shared PPU definitions: frame geometry defaults, framebuffer addressing,
// scanout state encoding and the scanout buffer entry layout.
package ppu_pkg;

    localparam int unsigned H_PIXELS_DEF = 160;
    localparam int unsigned V_PIXELS_DEF = 144;
    localparam int unsigned FB_ADDR_W    = 15;
    localparam int unsigned PIX_ENTRY_W  = 4;

    typedef enum logic [1:0] {
        SCAN_IDLE   = 2'd0,
        SCAN_ARMED  = 2'd1,
        SCAN_STREAM = 2'd2,
        SCAN_DRAIN  = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic [1:0] idx;
        logic       sof;
        logic       eol;
    } pix_entry_t;

    // Map a 2-bit colour index through a 4-entry, 2-bit-per-entry palette.
    function automatic logic [1:0] palette_shade(input logic [7:0] pal, input logic [1:0] idx);
        logic [1:0] shade;
        case (idx)
            2'd0:    shade = pal[1:0];
            2'd1:    shade = pal[3:2];
            2'd2:    shade = pal[5:4];
            default: shade = pal[7:6];
        endcase
        return shade;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset; push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             cpu_clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; occupancy gates every read of it.
    always_ff @(posedge cpu_clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_scanout.sv
// Frame scanout: on a vblank rising edge reads the whole framebuffer in raster
// order, maps colour indices through a per-frame latched palette and streams shades.
module lcd_scanout
    import ppu_pkg::*;
#(
    parameter int unsigned H_PIXELS   = H_PIXELS_DEF,
    parameter int unsigned V_PIXELS   = V_PIXELS_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 cpu_clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 vblank,
    input  logic [7:0]           bgp,
    output logic                 fb_rd,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [1:0]           fb_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [1:0]           pix_data,
    output logic                 pix_sof,
    output logic                 pix_eol,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);

    localparam int unsigned X_W   = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int unsigned Y_W   = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    scan_state_t          state_q;
    scan_state_t          state_d;
    logic                 vblank_q;
    logic [7:0]           pal_q;
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [FB_ADDR_W-1:0] addr_q;
    logic                 rd_q;
    logic                 tag_sof_q;
    logic                 tag_eol_q;
    logic                 overrun_q;

    logic                 vb_rise;
    logic                 issue;
    logic                 last_px;
    logic                 line_end;
    logic                 start_c;
    logic                 done_c;
    logic                 pop;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    pix_entry_t           push_entry;
    pix_entry_t           head;

    assign vb_rise  = vblank && !vblank_q;
    assign line_end = (x_q == X_W'(H_PIXELS - 1));
    assign last_px  = line_end && (y_q == Y_W'(V_PIXELS - 1));
    // Reads already in flight count against buffer space so a push never finds it full.
    assign issue    = (state_q == SCAN_STREAM) &&
                      ((32'(fifo_count) + 32'(rd_q)) < FIFO_DEPTH);

    // Next-state and frame-boundary strobes.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            SCAN_IDLE: begin
                if (enable) state_d = SCAN_ARMED;
            end
            SCAN_ARMED: begin
                if (!enable) begin
                    state_d = SCAN_IDLE;
                end else if (vb_rise) begin
                    state_d = SCAN_STREAM;
                    start_c = 1'b1;
                end
            end
            SCAN_STREAM: begin
                if (issue && last_px) state_d = SCAN_DRAIN;
            end
            SCAN_DRAIN: begin
                if (fifo_empty && !rd_q) begin
                    state_d = enable ? SCAN_ARMED : SCAN_IDLE;
                    done_c  = 1'b1;
                end
            end
            default: state_d = SCAN_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state_q   <= SCAN_IDLE;
            vblank_q  <= 1'b0;
            pal_q     <= 8'h00;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            tag_sof_q <= 1'b0;
            tag_eol_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vblank_q <= vblank;
            rd_q     <= issue;
            if (start_c) begin
                pal_q  <= bgp;
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
            end
            if (issue) begin
                tag_sof_q <= (x_q == '0) && (y_q == '0);
                tag_eol_q <= line_end;
                if (last_px) begin
                    x_q    <= '0;
                    y_q    <= '0;
                    addr_q <= '0;
                end else begin
                    addr_q <= addr_q + FB_ADDR_W'(1);
                    if (line_end) begin
                        x_q <= '0;
                        y_q <= y_q + Y_W'(1);
                    end else begin
                        x_q <= x_q + X_W'(1);
                    end
                end
            end
            if (vb_rise && (state_q == SCAN_STREAM || state_q == SCAN_DRAIN)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign push_entry = '{idx: fb_data, sof: tag_sof_q, eol: tag_eol_q};
    assign pop        = pix_valid && pix_ready;

    sync_fifo #(
        .WIDTH (PIX_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .push      (rd_q),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Outputs are forced quiet while reset is asserted, not only after it lands.
    assign fb_rd      = !reset && issue;
    assign fb_addr    = reset ? '0 : addr_q;
    assign pix_valid  = !reset && !fifo_empty;
    assign pix_data   = pix_valid ? palette_shade(pal_q, head.idx) : 2'b00;
    assign pix_sof    = pix_valid && head.sof;
    assign pix_eol    = pix_valid && head.eol;
    assign busy       = !reset && (state_q == SCAN_STREAM || state_q == SCAN_DRAIN);
    assign frame_done = !reset && done_c;
    assign overrun    = !reset && overrun_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Directed bench for lcd_scanout: full frames, palette latching, overrun,
// backpressure, mid-frame reset and enable drop.
module tb_lcd_scanout;

    localparam int H     = 160;
    localparam int V     = 144;
    localparam int NPIX  = H * V;
    localparam int DEPTH = 4;

    logic        cpu_clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        vblank;
    logic [7:0]  bgp;
    logic        fb_rd;
    logic [14:0] fb_addr;
    logic [1:0]  fb_data = 2'b00;
    logic        pix_valid;
    logic        pix_ready;
    logic [1:0]  pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    always #5 cpu_clock = ~cpu_clock;

    lcd_scanout #(
        .H_PIXELS   (H),
        .V_PIXELS   (V),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .cpu_clock  (cpu_clock),
        .reset      (reset),
        .enable     (enable),
        .vblank     (vblank),
        .bgp        (bgp),
        .fb_rd      (fb_rd),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // Framebuffer model: colour index is addr[1:0], or all zero in mode 1.
    logic ref_mode = 1'b0;
    always @(posedge cpu_clock) begin
        if (fb_rd) fb_data <= ref_mode ? 2'b00 : fb_addr[1:0];
    end

    // Written only by the stimulus block.
    logic [7:0] ref_pal  = 8'h00;
    int         mon_base = 0;
    logic       rand_ready = 1'b0;

    // Written only by the monitor.
    int         pix_total  = 0;
    int         bad_cnt    = 0;
    int         sof_cnt    = 0;
    int         eol_cnt    = 0;
    int         fd_cnt     = 0;
    int         out_cnt    = 0;
    int         out_viol   = 0;
    int         stable_bad = 0;
    logic       held       = 1'b0;
    logic [3:0] held_v     = 4'h0;
    int         mon_rel;
    logic [1:0] mon_ci;
    logic [1:0] mon_shade;

    always @(negedge cpu_clock) begin
        if (reset) begin
            out_cnt = 0;
            held    = 1'b0;
        end else begin
            if (frame_done) fd_cnt++;
            if (fb_rd) out_cnt++;
            if (held && (pix_valid !== 1'b1 || {pix_data, pix_sof, pix_eol} !== held_v))
                stable_bad++;
            if (pix_valid && pix_ready) begin
                mon_rel   = pix_total - mon_base;
                mon_ci    = ref_mode ? 2'b00 : mon_rel[1:0];
                mon_shade = ref_pal[2*mon_ci +: 2];
                if (mon_rel >= NPIX || pix_data !== mon_shade ||
                    pix_sof !== (mon_rel == 0) || pix_eol !== ((mon_rel % H) == H - 1))
                    bad_cnt++;
                if (pix_sof) sof_cnt++;
                if (pix_eol) eol_cnt++;
                pix_total++;
                out_cnt--;
            end
            if (out_cnt > DEPTH) out_viol++;
            held   = pix_valid && !pix_ready;
            held_v = {pix_data, pix_sof, pix_eol};
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clock);
        #1;
        if (rand_ready) pix_ready = ($urandom_range(99, 0) < 30);
    endtask

    task automatic wait_pixels(input int n, input int budget, input string tag);
        int c = 0;
        while ((pix_total - mon_base) < n && c < budget) begin
            step();
            c++;
        end
        chk(tag, 32'((pix_total - mon_base) >= n), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int c = 0;
        int start = fd_cnt;
        while (fd_cnt == start && c < budget) begin
            step();
            c++;
        end
        chk(tag, 32'(fd_cnt != start), 32'd1);
    endtask

    int b_bad, b_sof, b_eol, b_fd, b_stable, b_tot, busy_seen;

    initial begin
        reset = 1'b1; enable = 1'b0; vblank = 1'b0; bgp = 8'h00; pix_ready = 1'b1;
        step(); step(); step();

        // Outputs while reset is held.
        @(negedge cpu_clock);
        chk("rst_fb_rd",      32'(fb_rd),      32'd0);
        chk("rst_fb_addr",    32'(fb_addr),    32'd0);
        chk("rst_pix_valid",  32'(pix_valid),  32'd0);
        chk("rst_pix_data",   32'(pix_data),   32'd0);
        chk("rst_pix_sof",    32'(pix_sof),    32'd0);
        chk("rst_pix_eol",    32'(pix_eol),    32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overrun",    32'(overrun),    32'd0);
        step();
        reset = 1'b0;

        // Frame A: full rate, palette E4 is identity, data = addr[1:0].
        ref_mode = 1'b0; ref_pal = 8'hE4; bgp = 8'hE4; enable = 1'b1;
        step(); step();
        chk("armed_not_busy", 32'(busy), 32'd0);
        b_bad = bad_cnt; b_sof = sof_cnt; b_eol = eol_cnt; b_fd = fd_cnt;
        mon_base = pix_total;
        vblank = 1'b1;
        step();
        @(negedge cpu_clock);
        chk("a_busy",        32'(busy),      32'd1);
        chk("a_first_rd",    32'(fb_rd),     32'd1);
        chk("a_first_addr",  32'(fb_addr),   32'd0);
        chk("a_latency0",    32'(pix_valid), 32'd0);
        step();
        @(negedge cpu_clock);
        chk("a_latency1",    32'(pix_valid), 32'd0);
        step();
        vblank = 1'b0;
        wait_done(30000, "a_done_timeout");
        step(); step(); step();
        chk("a_pixels",      32'(pix_total - mon_base), 32'(NPIX));
        chk("a_bad_pixels",  32'(bad_cnt - b_bad),      32'd0);
        chk("a_sof_count",   32'(sof_cnt - b_sof),      32'd1);
        chk("a_eol_count",   32'(eol_cnt - b_eol),      32'(V));
        chk("a_done_pulses", 32'(fd_cnt - b_fd),        32'd1);
        chk("a_overrun",     32'(overrun),              32'd0);
        chk("a_rearm_idle",  32'(busy),                 32'd0);

        // Frame B: palette 1B on all-zero data, bgp cleared mid-frame,
        // enable dropped at pixel 100, second vblank edge at pixel 5000.
        ref_mode = 1'b1; ref_pal = 8'h1B; bgp = 8'h1B;
        b_bad = bad_cnt; b_sof = sof_cnt; b_eol = eol_cnt; b_fd = fd_cnt;
        mon_base = pix_total;
        vblank = 1'b1;
        wait_pixels(100, 2000, "b_wait_100");
        enable = 1'b0;
        vblank = 1'b0;
        wait_pixels(3000, 5000, "b_wait_3000");
        bgp = 8'h00;
        wait_pixels(5000, 5000, "b_wait_5000");
        chk("b_overrun_pre", 32'(overrun), 32'd0);
        vblank = 1'b1;
        step();
        @(negedge cpu_clock);
        chk("b_overrun_set", 32'(overrun), 32'd1);
        chk("b_still_busy",  32'(busy),    32'd1);
        vblank = 1'b0;
        wait_done(30000, "b_done_timeout");
        step();
        chk("b_pixels",      32'(pix_total - mon_base), 32'(NPIX));
        chk("b_bad_pixels",  32'(bad_cnt - b_bad),      32'd0);
        chk("b_sof_count",   32'(sof_cnt - b_sof),      32'd1);
        chk("b_eol_count",   32'(eol_cnt - b_eol),      32'(V));
        chk("b_done_pulses", 32'(fd_cnt - b_fd),        32'd1);
        chk("b_idle_busy",   32'(busy),                 32'd0);
        busy_seen = 0;
        vblank = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (busy || fb_rd) busy_seen++;
        end
        vblank = 1'b0;
        chk("b_no_rearm",     32'(busy_seen), 32'd0);
        chk("b_overrun_held", 32'(overrun),   32'd1);

        // Frame C: 30% ready duty, then full rate, reset at pixel 10000.
        ref_mode = 1'b0; ref_pal = 8'hE4; bgp = 8'hE4; enable = 1'b1;
        step(); step();
        b_bad = bad_cnt; b_stable = stable_bad;
        mon_base = pix_total;
        rand_ready = 1'b1;
        vblank = 1'b1;
        step(); step(); step();
        vblank = 1'b0;
        wait_pixels(3000, 20000, "c_wait_3000");
        rand_ready = 1'b0;
        pix_ready = 1'b1;
        chk("c_stable_hold", 32'(stable_bad - b_stable), 32'd0);
        wait_pixels(10000, 12000, "c_wait_10000");
        chk("c_bad_pixels",  32'(bad_cnt - b_bad),       32'd0);
        chk("c_outstanding", 32'(out_viol),              32'd0);
        reset = 1'b1;
        @(negedge cpu_clock);
        chk("c_rst_cycle_valid", 32'(pix_valid), 32'd0);
        chk("c_rst_cycle_rd",    32'(fb_rd),     32'd0);
        step();
        reset = 1'b0;
        @(negedge cpu_clock);
        chk("c_post_valid",   32'(pix_valid), 32'd0);
        chk("c_post_addr",    32'(fb_addr),   32'd0);
        chk("c_post_busy",    32'(busy),      32'd0);
        chk("c_post_overrun", 32'(overrun),   32'd0);
        b_tot = pix_total;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy || pix_valid) busy_seen++;
        end
        chk("c_no_residual", 32'(pix_total - b_tot + busy_seen), 32'd0);

        // Restart after reset needs a fresh vblank edge and begins at pixel 0.
        b_bad = bad_cnt; b_sof = sof_cnt;
        mon_base = pix_total;
        vblank = 1'b1;
        wait_pixels(20, 200, "c_restart_20");
        chk("c_restart_bad", 32'(bad_cnt - b_bad), 32'd1 - 32'd1);
        chk("c_restart_sof", 32'(sof_cnt - b_sof), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
